// File: rtl/eva_intr_ctrl_if.sv
// AHB-Lite slave port bundle for eva_intr_ctrl. Groups the bus signals so the
// controller and its bus master share one declaration.
interface eva_intr_ctrl_if;
  // Handshake: a transfer is accepted when hsel & htrans[1] & hready_in are all
  // high at a clock edge. The data phase completes on the first edge where
  // hready_out is high. hresp is valid for every cycle of the data phase.
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  hsize;
  logic        hready_in;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, htrans, hwrite, haddr, hwdata, hsize, hready_in,
    input  hready_out, hresp, hrdata
  );

  modport slave (
    input  hsel, htrans, hwrite, haddr, hwdata, hsize, hready_in,
    output hready_out, hresp, hrdata
  );
endinterface

// File: rtl/eva_intr_ctrl.sv
// Parametrised interrupt controller: per-channel edge/level, polarity, mask,
// sticky W1C pending, aggregated irq with lowest-index id, AHB-Lite registers.
module eva_intr_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               hclk,
  input  logic               hrst_n,
  eva_intr_ctrl_if.slave     ahb,
  input  logic [NUM_IRQ-1:0] intr_in,
  output logic               irq,
  output logic [4:0]         irq_id,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'd0;
  localparam logic [1:0] RESP_ERROR = 2'd1;

  logic [NUM_IRQ-1:0] w_sync;
  logic [NUM_IRQ-1:0] r_hist;
  logic [NUM_IRQ-1:0] r_mode;
  logic [NUM_IRQ-1:0] r_pol;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] w_act;
  logic [NUM_IRQ-1:0] w_act_prev;
  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_pend_next;
  logic [NUM_IRQ-1:0] w_active;
  logic [15:0]        r_count;
  logic               r_irq;
  logic               r_irq_prev;
  logic [4:0]         r_irq_id;
  logic [4:0]         w_id;
  logic               w_any;

  state_t             r_state;
  logic               r_hready_out;
  logic [1:0]         r_hresp;
  logic               r_dp_valid;
  logic               r_dp_write;
  logic [2:0]         r_dp_addr;
  logic               w_accept;
  logic               w_err;
  logic               w_wr_en;
  logic [31:0]        w_rdata;
  logic               w_unused;

  function automatic logic [31:0] zext(input logic [NUM_IRQ-1:0] v);
    zext = '0;
    zext[NUM_IRQ-1:0] = v;
  endfunction

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_sync = intr_in;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
      always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
          for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
          r_sync[0] <= intr_in;
          for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
      end
      assign w_sync = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // History holds the pre-polarity value, so a POL write never fakes an edge.
  assign w_act      = w_sync ^ r_pol;
  assign w_act_prev = r_hist ^ r_pol;
  assign w_edge     = w_act & ~w_act_prev;

  assign w_wr_en     = r_dp_valid & r_dp_write;
  assign w_w1c       = (w_wr_en && r_dp_addr == 3'd4) ? ahb.hwdata[NUM_IRQ-1:0] : '0;
  assign w_pend_next = (r_mode & (w_edge | (r_pend & ~w_w1c))) | (~r_mode & w_act);
  assign w_active    = r_pend & r_mask;
  assign w_any       = |w_active;

  always_comb begin
    w_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) w_id = 5'(i);
    end
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_hist     <= '0;
      r_mode     <= '0;
      r_pol      <= '0;
      r_mask     <= '0;
      r_pend     <= '0;
      r_count    <= '0;
      r_irq      <= 1'b0;
      r_irq_prev <= 1'b0;
      r_irq_id   <= '0;
    end else begin
      r_hist     <= w_sync;
      r_pend     <= w_pend_next;
      r_irq      <= w_any;
      r_irq_id   <= w_id;
      r_irq_prev <= r_irq;
      if (w_wr_en) begin
        case (r_dp_addr)
          3'd1:    r_mode <= ahb.hwdata[NUM_IRQ-1:0];
          3'd2:    r_pol  <= ahb.hwdata[NUM_IRQ-1:0];
          3'd3:    r_mask <= ahb.hwdata[NUM_IRQ-1:0];
          default: ;
        endcase
      end
      // A COUNT write wins over a coincident increment.
      if (w_wr_en && r_dp_addr == 3'd6) begin
        r_count <= '0;
      end else if (r_irq && !r_irq_prev && r_count != 16'hFFFF) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign w_err    = (ahb.hsize != 2'd2) || (ahb.haddr[4:2] == 3'd7);
  assign w_accept = ahb.hsel & ahb.htrans[1] & ahb.hready_in & (r_state != ST_ERR1);

  // Error responses take two cycles; only the second one may accept a new transfer.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_state      <= ST_IDLE;
      r_hready_out <= 1'b1;
      r_hresp      <= RESP_OKAY;
      r_dp_valid   <= 1'b0;
      r_dp_write   <= 1'b0;
      r_dp_addr    <= '0;
    end else begin
      r_dp_valid <= w_accept & ~w_err;
      if (w_accept) begin
        r_dp_write <= ahb.hwrite;
        r_dp_addr  <= ahb.haddr[4:2];
      end
      case (r_state)
        ST_ERR1: begin
          r_state      <= ST_ERR2;
          r_hready_out <= 1'b1;
          r_hresp      <= RESP_ERROR;
        end
        default: begin
          if (w_accept && w_err) begin
            r_state      <= ST_ERR1;
            r_hready_out <= 1'b0;
            r_hresp      <= RESP_ERROR;
          end else begin
            r_state      <= ST_IDLE;
            r_hready_out <= 1'b1;
            r_hresp      <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_dp_valid && !r_dp_write) begin
      case (r_dp_addr)
        3'd0:    w_rdata = zext(w_act);
        3'd1:    w_rdata = zext(r_mode);
        3'd2:    w_rdata = zext(r_pol);
        3'd3:    w_rdata = zext(r_mask);
        3'd4:    w_rdata = zext(r_pend);
        3'd5:    w_rdata = {r_irq, 26'b0, r_irq_id};
        3'd6:    w_rdata = {16'b0, r_count};
        default: w_rdata = '0;
      endcase
    end
  end

  assign ahb.hready_out = r_hready_out;
  assign ahb.hresp      = r_hresp;
  assign ahb.hrdata     = w_rdata;
  assign irq            = r_irq;
  assign irq_id         = r_irq_id;
  assign o_dbg_state    = r_state;

  assign w_unused = ^{ahb.haddr[31:5], ahb.haddr[1:0], ahb.hwdata};

endmodule

// File: tb/tb_eva_intr_ctrl.sv
// Self-checking bench for eva_intr_ctrl (NUM_IRQ=8, SYNC_STAGES=2): directed
// scenarios plus randomized traffic against a settled-state behavioural model.
module tb_eva_intr_ctrl;
  localparam int N = 8;

  logic         hclk = 1'b0;
  logic         hrst_n = 1'b0;
  logic [N-1:0] intr_in;
  logic         irq;
  logic [4:0]   irq_id;
  logic [1:0]   unused_dbg_state;
  int           errors = 0;
  int           checks = 0;

  eva_intr_ctrl_if ahb();
  assign ahb.hready_in = ahb.hready_out;

  eva_intr_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(2)) dut (
    .hclk(hclk), .hrst_n(hrst_n), .ahb(ahb), .intr_in(intr_in),
    .irq(irq), .irq_id(irq_id), .o_dbg_state(unused_dbg_state)
  );

  always #5 hclk = ~hclk;

  // Behavioural model: register contents after the design has settled.
  logic [7:0] m_mode, m_pol, m_mask, m_pend, m_in;
  int         m_count;
  logic       m_irq;

  function automatic void model_reset();
    m_mode = '0; m_pol = '0; m_mask = '0; m_pend = '0; m_in = intr_in;
    m_count = 0; m_irq = 1'b0;
  endfunction

  function automatic void model_eval();
    logic nirq;
    nirq = |(m_pend & m_mask);
    if (nirq && !m_irq && m_count < 65535) m_count++;
    m_irq = nirq;
  endfunction

  function automatic logic [4:0] model_id();
    for (int i = 0; i < N; i++) if (m_pend[i] & m_mask[i]) return 5'(i);
    return 5'd0;
  endfunction

  function automatic void model_in(input logic [7:0] v);
    logic [7:0] old_act, new_act;
    old_act = m_in ^ m_pol;
    new_act = v ^ m_pol;
    m_in = v;
    m_pend = (m_mode & (m_pend | (new_act & ~old_act))) | (~m_mode & new_act);
    model_eval();
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] d);
    case (addr[4:2])
      3'd1: m_mode = d[7:0];
      3'd2: m_pol  = d[7:0];
      3'd3: m_mask = d[7:0];
      3'd4: m_pend = m_pend & ~(d[7:0] & m_mode);
      3'd6: m_count = 0;
      default: ;
    endcase
    m_pend = (m_pend & m_mode) | (~m_mode & (m_in ^ m_pol));
    model_eval();
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    case (addr[4:2])
      3'd0: return {24'b0, m_in ^ m_pol};
      3'd1: return {24'b0, m_mode};
      3'd2: return {24'b0, m_pol};
      3'd3: return {24'b0, m_mask};
      3'd4: return {24'b0, m_pend};
      3'd5: return {m_irq, 26'b0, (m_irq ? model_id() : 5'd0)};
      3'd6: return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge hclk); #1; end
  endtask

  task automatic bus_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, output logic [31:0] rdata,
                          output logic rdy1, output logic [1:0] resp1,
                          output logic rdy2, output logic [1:0] resp2);
    ahb.hsel = 1'b1; ahb.htrans = 2'b10; ahb.hwrite = wr; ahb.haddr = addr; ahb.hsize = size;
    @(posedge hclk); #1;
    ahb.hsel = 1'b0; ahb.htrans = 2'b00; ahb.hwdata = wdata;
    rdata = ahb.hrdata; rdy1 = ahb.hready_out; resp1 = ahb.hresp;
    rdy2 = rdy1; resp2 = resp1;
    if (!rdy1) begin
      @(posedge hclk); #1;
      rdy2 = ahb.hready_out; resp2 = ahb.hresp;
    end
    @(posedge hclk); #1;
  endtask

  task automatic reg_write(input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] rd; logic r1, r2; logic [1:0] s1, s2;
    bus_xfer(1'b1, addr, d, 2'd2, rd, r1, s1, r2, s2);
    model_write(addr, d);
    idle(4);
  endtask

  task automatic reg_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] resp);
    logic r1, r2; logic [1:0] s2;
    bus_xfer(1'b0, addr, 32'd0, 2'd2, d, r1, resp, r2, s2);
  endtask

  task automatic set_in(input logic [7:0] v, input int hold);
    intr_in = v;
    model_in(v);
    idle(hold);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] resp;
    checks++;
    if (ahb.hready_out !== 1'b1 || ahb.hresp !== 2'd0 || ahb.hrdata !== 32'd0 || irq !== 1'b0 || irq_id !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b resp=%0d rdata=%h irq=%b id=%0d, expected 1 0 0 0 0",
               ahb.hready_out, ahb.hresp, ahb.hrdata, irq, irq_id);
    end
    for (int a = 0; a <= 6; a++) begin
      reg_read(32'(a * 4), d, resp);
      checks++;
      if (d !== 32'd0 || resp !== 2'd0) begin
        errors++;
        $display("FAIL reset_read_%0h: got %h resp %0d, expected 0 resp 0", a * 4, d, resp);
      end
    end
  endtask

  task automatic test_edge_pulse();
    logic [31:0] d; logic [1:0] resp;
    reg_write(32'h04, 32'hFF);
    reg_write(32'h0C, 32'h28);
    set_in(8'h28, 3);
    set_in(8'h00, 6);
    reg_read(32'h10, d, resp);
    checks++;
    if (d !== 32'h28) begin errors++; $display("FAIL edge_pend: got %h expected 00000028", d); end
    reg_read(32'h14, d, resp);
    checks++;
    if (d !== 32'h80000003) begin errors++; $display("FAIL edge_id: got %h expected 80000003", d); end
    checks++;
    if (irq !== 1'b1 || irq_id !== 5'd3) begin errors++; $display("FAIL edge_pins: got irq=%b id=%0d expected 1 3", irq, irq_id); end
    reg_read(32'h18, d, resp);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL edge_count: got %h expected 00000001", d); end
    reg_write(32'h10, 32'h08);
    reg_read(32'h14, d, resp);
    checks++;
    if (d !== 32'h80000005) begin errors++; $display("FAIL w1c_id: got %h expected 80000005", d); end
    reg_write(32'h10, 32'h20);
    checks++;
    if (irq !== 1'b0 || irq_id !== 5'd0) begin errors++; $display("FAIL w1c_irq: got irq=%b id=%0d expected 0 0", irq, irq_id); end
  endtask

  task automatic test_level_pol();
    logic [31:0] d; logic [1:0] resp;
    reg_write(32'h04, 32'h00);
    reg_write(32'h08, 32'h04);
    reg_write(32'h0C, 32'h04);
    reg_read(32'h10, d, resp);
    checks++;
    if (d !== 32'h04) begin errors++; $display("FAIL level_pend: got %h expected 00000004", d); end
    reg_write(32'h10, 32'h04);
    reg_read(32'h10, d, resp);
    checks++;
    if (d !== 32'h04) begin errors++; $display("FAIL level_w1c: got %h expected 00000004", d); end
    intr_in = 8'h04;
    model_in(8'h04);
    for (int k = 1; k <= 4; k++) begin
      @(posedge hclk); #1;
      checks++;
      if (irq !== (k <= 3)) begin
        errors++;
        $display("FAIL level_latency_c%0d: got irq=%b expected %b", k, irq, (k <= 3));
      end
    end
    idle(4);
    reg_read(32'h10, d, resp);
    checks++;
    if (d !== 32'h00) begin errors++; $display("FAIL level_release: got %h expected 00000000", d); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d; logic r1, r2; logic [1:0] s1, s2, resp;
    reg_write(32'h04, 32'h01);
    intr_in = 8'h05;
    @(posedge hclk); #1;
    bus_xfer(1'b1, 32'h10, 32'h01, 2'd2, d, r1, s1, r2, s2);
    model_write(32'h10, 32'h01);
    model_in(8'h05);
    idle(4);
    reg_read(32'h10, d, resp);
    checks++;
    if (d[0] !== 1'b1) begin errors++; $display("FAIL set_wins: got pend %h expected bit0 set", d); end
  endtask

  task automatic test_error();
    logic [31:0] d; logic r1, r2; logic [1:0] s1, s2, resp;
    ahb.hsel = 1'b1; ahb.htrans = 2'b10; ahb.hwrite = 1'b0; ahb.haddr = 32'h1C; ahb.hsize = 2'd2;
    @(posedge hclk); #1;
    ahb.hsel = 1'b0; ahb.htrans = 2'b00;
    checks++;
    if (ahb.hready_out !== 1'b0 || ahb.hresp !== 2'd1 || ahb.hrdata !== 32'd0) begin
      errors++;
      $display("FAIL err_cycle1: got rdy=%b resp=%0d rdata=%h expected 0 1 0", ahb.hready_out, ahb.hresp, ahb.hrdata);
    end
    @(posedge hclk); #1;
    checks++;
    if (ahb.hready_out !== 1'b1 || ahb.hresp !== 2'd1) begin
      errors++;
      $display("FAIL err_cycle2: got rdy=%b resp=%0d expected 1 1", ahb.hready_out, ahb.hresp);
    end
    ahb.hsel = 1'b1; ahb.htrans = 2'b10; ahb.hwrite = 1'b0; ahb.haddr = 32'h0C;
    @(posedge hclk); #1;
    ahb.hsel = 1'b0; ahb.htrans = 2'b00;
    checks++;
    if (ahb.hready_out !== 1'b1 || ahb.hresp !== 2'd0 || ahb.hrdata !== {24'b0, m_mask}) begin
      errors++;
      $display("FAIL err_then_read: got rdy=%b resp=%0d rdata=%h expected 1 0 %h", ahb.hready_out, ahb.hresp, ahb.hrdata, m_mask);
    end
    @(posedge hclk); #1;
    bus_xfer(1'b1, 32'h0C, 32'hFF, 2'd1, d, r1, s1, r2, s2);
    checks++;
    if (r1 !== 1'b0 || s1 !== 2'd1 || r2 !== 1'b1 || s2 !== 2'd1) begin
      errors++;
      $display("FAIL err_hsize: got rdy %b,%b resp %0d,%0d expected 0,1 1,1", r1, r2, s1, s2);
    end
    idle(2);
    reg_read(32'h0C, d, resp);
    checks++;
    if (d !== {24'b0, m_mask} || resp !== 2'd0) begin
      errors++;
      $display("FAIL err_no_update: got %h resp %0d expected %h resp 0", d, resp, m_mask);
    end
  endtask

  task automatic test_back_to_back();
    ahb.hsel = 1'b1; ahb.htrans = 2'b10; ahb.hwrite = 1'b1; ahb.haddr = 32'h0C; ahb.hsize = 2'd2;
    @(posedge hclk); #1;
    ahb.hwdata = 32'h21; ahb.hwrite = 1'b0;
    @(posedge hclk); #1;
    ahb.hsel = 1'b0; ahb.htrans = 2'b00;
    checks++;
    if (ahb.hrdata !== 32'h21 || ahb.hresp !== 2'd0 || ahb.hready_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_raw: got rdata=%h resp=%0d expected 00000021 resp 0", ahb.hrdata, ahb.hresp);
    end
    @(posedge hclk); #1;
    model_write(32'h0C, 32'h21);
    idle(4);
    checks++;
    if (irq !== m_irq || irq_id !== model_id()) begin
      errors++;
      $display("FAIL b2b_pins: got irq=%b id=%0d expected %b %0d", irq, irq_id, m_irq, model_id());
    end
  endtask

  task automatic test_count_sat();
    logic [31:0] d; logic [1:0] resp;
    reg_write(32'h04, 32'h00);
    reg_write(32'h08, 32'h00);
    reg_write(32'h0C, 32'h01);
    set_in(8'h00, 6);
    reg_write(32'h18, $urandom);
    for (int i = 0; i < 5; i++) begin set_in(8'h01, 3); set_in(8'h00, 3); end
    reg_read(32'h18, d, resp);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL count_5: got %h expected 00000005", d); end
    // Preload near the top to reach saturation without 65535 real rises.
    force dut.r_count = 16'hFFFC;
    @(posedge hclk); #1;
    release dut.r_count;
    m_count = 65532;
    for (int i = 0; i < 6; i++) begin set_in(8'h01, 3); set_in(8'h00, 3); end
    reg_read(32'h18, d, resp);
    checks++;
    if (d !== 32'h0000FFFF) begin errors++; $display("FAIL count_sat: got %h expected 0000ffff", d); end
    reg_write(32'h18, 32'h1234);
    reg_read(32'h18, d, resp);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL count_clear: got %h expected 00000000", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] resp;
    ahb.hsel = 1'b1; ahb.htrans = 2'b10; ahb.hwrite = 1'b0; ahb.haddr = 32'h1C; ahb.hsize = 2'd2;
    @(posedge hclk); #1;
    ahb.hsel = 1'b0; ahb.htrans = 2'b00;
    intr_in = 8'h00;
    hrst_n = 1'b0;
    #1;
    checks++;
    if (ahb.hready_out !== 1'b1 || ahb.hresp !== 2'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b resp=%0d irq=%b expected 1 0 0", ahb.hready_out, ahb.hresp, irq);
    end
    idle(2);
    hrst_n = 1'b1;
    model_reset();
    idle(2);
    reg_read(32'h0C, d, resp);
    checks++;
    if (d !== 32'd0 || resp !== 2'd0) begin errors++; $display("FAIL reset_mid_read: got %h resp %0d expected 0 resp 0", d, resp); end
  endtask

  task automatic test_random();
    logic [31:0] d, exp_d, addr; logic [1:0] resp; logic [7:0] v;
    for (int it = 0; it < 60; it++) begin
      v = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0, 5: set_in(v, 6);
        1: reg_write(32'h04, {24'b0, v});
        2: reg_write(32'h08, {24'b0, v});
        3: reg_write(32'h0C, {24'b0, v});
        default: reg_write(32'h10, {24'b0, v});
      endcase
      checks++;
      if (irq !== m_irq || irq_id !== model_id()) begin
        errors++;
        $display("FAIL rand_pins_%0d: got irq=%b id=%0d expected %b %0d", it, irq, irq_id, m_irq, model_id());
      end
      reg_read(32'h10, d, resp);
      checks++;
      if (d !== {24'b0, m_pend}) begin errors++; $display("FAIL rand_pend_%0d: got %h expected %h", it, d, m_pend); end
      addr = 32'($urandom_range(0, 6) * 4);
      exp_d = model_read(addr);
      reg_read(addr, d, resp);
      checks++;
      if (d !== exp_d || resp !== 2'd0) begin
        errors++;
        $display("FAIL rand_read_%0d_%0h: got %h resp %0d expected %h", it, addr, d, resp, exp_d);
      end
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    ahb.hsel = 1'b0; ahb.htrans = 2'b00; ahb.hwrite = 1'b0; ahb.haddr = '0;
    ahb.hwdata = '0; ahb.hsize = 2'd2;
    intr_in = '0;
    model_reset();
    repeat (3) @(posedge hclk);
    #1;
    hrst_n = 1'b1;
    idle(2);
    test_reset();
    test_edge_pulse();
    test_level_pol();
    test_set_wins();
    test_error();
    test_back_to_back();
    test_count_sat();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
